// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the shared-bus arbiter.
// Optional hold limit: define BUS_ARB_HOLD_LIMIT_EN.
package bus_arb_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OWN   = 2'd2,
    TURN  = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_ctrl_rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or after rr_ptr, wrapping modulo N.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter  int N = NUM_REQ_DEF,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  int         j;
  logic [W-1:0] k;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      k = W'(j);
      if (!valid && req[k]) begin
        valid = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/bus_arb_ctrl.sv
// Shared-bus arbiter: IDLE/GRANT/OWN/TURN with a mandatory
// one-cycle turnaround. Hold limit under BUS_ARB_HOLD_LIMIT_EN.
module bus_arb_ctrl
  import bus_arb_pkg::*;
#(
  parameter  int NUM_REQ  = NUM_REQ_DEF,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int W        = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] drv_en,
  output logic [W-1:0]       owner,
  output logic               busy,
  output logic               timeout
);

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] rr_ptr;
  logic [W-1:0] pick_idx;
  logic [W-1:0] ptr_nx;
  logic         pick_vld;
  logic         own_req;
  logic         own_last;
  logic         hit;
  logic         arb;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .idx    (pick_idx)
  );

  assign own_req  = req[owner];
  assign own_last = last[owner];
  assign arb      = (state == IDLE) || (state == TURN);
  assign ptr_nx   = (pick_idx == W'(NUM_REQ - 1))
                  ? '0 : pick_idx + 1'b1;

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt;
  logic          timeout_q;

  assign hit = (hold_cnt == HW'(MAX_HOLD - 1));

  // A simultaneous last or req drop wins over the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= (state == OWN) ? hold_cnt + 1'b1 : '0;
      timeout_q <= (state == OWN) && hit
                && own_req && !own_last;
    end
  end

  assign timeout = timeout_q;
`else
  assign hit     = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (arb && pick_vld) begin
        owner  <= pick_idx;
        rr_ptr <= ptr_nx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (pick_vld) state_nx = GRANT;
      GRANT: state_nx = own_req ? OWN : TURN;
      OWN:   if (own_last || !own_req || hit)
               state_nx = TURN;
      TURN:  state_nx = pick_vld ? GRANT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt    = '0;
    drv_en = '0;
    busy   = (state != IDLE);
    case (state)
      GRANT: gnt[owner] = 1'b1;
      OWN: begin
        gnt[owner]    = 1'b1;
        drv_en[owner] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arb_ctrl.sv
// Self-checking bench for bus_arb_ctrl: vector table, corner
// sequences and a randomized run against a tenure-level model.
module tb_bus_arb_ctrl;

  localparam int N  = 4;
  localparam int MH = 8;
`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] gnt;
  logic [3:0] drv_en;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arb_ctrl #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .last    (last),
    .gnt     (gnt),
    .drv_en  (drv_en),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] gnt;
    logic [3:0] drv;
    logic       busy;
    logic       to;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] g,
                         input logic [3:0] d, input logic b,
                         input logic t);
    chk(nm, {22'd0, gnt, drv_en, busy, timeout},
            {22'd0, g, d, b, t});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    last  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // tenure-level reference model
  int         m_holder;
  int         m_age;
  int         m_ptr;
  bit         m_gap;
  bit         m_to;
  logic [3:0] e_g;
  logic [3:0] e_d;
  logic       e_b;

  task automatic model_step(input logic [3:0] r,
                            input logic [3:0] l);
    bit ends;
    bit lim;
    m_to = 1'b0;
    if (m_holder >= 0) begin
      if (m_age == 0) begin
        if (r[m_holder]) m_age = 1;
        else begin
          m_holder = -1;
          m_gap    = 1'b1;
        end
      end else begin
        lim  = HOLD_EN && (m_age == MH);
        ends = l[m_holder] || !r[m_holder];
        if (ends || lim) begin
          m_to     = lim && !ends;
          m_holder = -1;
          m_gap    = 1'b1;
        end else m_age++;
      end
    end else begin
      m_gap = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_holder < 0 && r[(m_ptr + i) % N]) begin
          m_holder = (m_ptr + i) % N;
          m_age    = 0;
        end
      end
      if (m_holder >= 0) m_ptr = (m_holder + 1) % N;
    end
  endtask

  vec_t tbl[10];

  initial begin
    logic [3:0] one;
    int         n_drv;

    tbl[0] = '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{4'h1, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[2] = '{4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0};
    tbl[3] = '{4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0};
    tbl[4] = '{4'h1, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0};
    tbl[5] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[6] = '{4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[7] = '{4'h0, 4'h0, 4'h2, 4'h0, 1'b1, 1'b0};
    tbl[8] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[9] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = '0;
    last  = '0;
    #3;
    chk_out("reset_outputs", 4'h0, 4'h0, 1'b0, 1'b0);
    chk("reset_owner", 32'(owner), 32'd0);
    do_reset();

    // single tenure then an aborted grant
    for (int i = 0; i < 10; i++) begin
      req  = tbl[i].req;
      last = tbl[i].last;
      chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].drv,
              tbl[i].busy, tbl[i].to);
      tick();
    end

    // round robin with all requesters active
    do_reset();
    req = 4'hf;
    chk_out("rr_idle", 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      one = 4'b0001 << (k % 4);
      chk_out($sformatf("rr%0d_grant", k), one, 4'h0, 1'b1, 1'b0);
      chk($sformatf("rr%0d_owner", k), 32'(owner), 32'(k % 4));
      tick();
      chk_out($sformatf("rr%0d_own1", k), one, one, 1'b1, 1'b0);
      tick();
      last = one;
      chk_out($sformatf("rr%0d_own2", k), one, one, 1'b1, 1'b0);
      tick();
      last = '0;
      if (k == 4) req = '0;
      chk_out($sformatf("rr%0d_turn", k), 4'h0, 4'h0, 1'b1, 1'b0);
      tick();
    end
    chk_out("rr_end_idle", 4'h0, 4'h0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a tenure
    do_reset();
    req = 4'h1;
    tick();
    tick();
    chk("arst_pre_drv", 32'(drv_en), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("arst_drop", 4'h0, 4'h0, 1'b0, 1'b0);
    chk("arst_owner", 32'(owner), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'h4;
    tick();
    chk("arst_owner2", 32'(owner), 32'd2);
    chk_out("arst_grant2", 4'h4, 4'h0, 1'b1, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req   = 4'h9;
    tick();
    chk("arst_ptr_restart", 32'(owner), 32'd0);
    req = '0;
    tick();
    tick();
    chk_out("arst_idle", 4'h0, 4'h0, 1'b0, 1'b0);

`ifdef BUS_ARB_HOLD_LIMIT_EN
    // hold limit cuts a tenure with no last
    do_reset();
    req   = 4'h4;
    n_drv = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (timeout) break;
      if (drv_en[2]) n_drv++;
    end
    chk("hold_drv_cycles", 32'(n_drv), 32'd8);
    chk_out("hold_timeout", 4'h0, 4'h0, 1'b1, 1'b1);
    tick();
    chk_out("hold_to_pulse", 4'h4, 4'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 8) last = 4'h4;
    end
    tick();
    last = '0;
    req  = '0;
    chk_out("hold_last_wins", 4'h0, 4'h0, 1'b1, 1'b0);
    tick();
`endif

    // randomized run against the reference model
    do_reset();
    m_holder = -1;
    m_age    = 0;
    m_ptr    = 0;
    m_gap    = 1'b0;
    m_to     = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      e_g = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'h0;
      e_d = (m_holder >= 0 && m_age >= 1) ? e_g : 4'h0;
      e_b = (m_holder >= 0) || m_gap;
      chk_out($sformatf("rand%0d", c), e_g, e_d, e_b, m_to);
      if (m_holder >= 0)
        chk($sformatf("rand%0d_owner", c), 32'(owner),
            32'(m_holder));
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
        last[b] = (c < 1500) ? ($urandom_range(3) == 0)
                             : ($urandom_range(15) == 0);
      end
      model_step(req, last);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
